// File: rtl/riscv_core_booth_r4.sv
// Radix-4 Booth multi-cycle multiplier (MUL/MULH/MULHSU/MULHU/MULW), 2 multiplier bits per cycle, valid/ready + flush.
// Optional RISCV_BOOTH_ZERO_SKIP_EN: a zero operand goes straight to DONE with result 0.
module riscv_core_booth_r4 #(
  parameter int XLEN = 64
) (
  input  logic            i_mul_clk,
  input  logic            i_mul_rst,
  input  logic            i_mul_valid,
  output logic            o_mul_ready,
  input  logic [1:0]      i_mul_op,
  input  logic            i_mul_word,
  input  logic [XLEN-1:0] i_mul_rs1,
  input  logic [XLEN-1:0] i_mul_rs2,
  input  logic            i_mul_flush,
  output logic            o_mul_valid,
  input  logic            i_mul_out_ready,
  output logic [XLEN-1:0] o_mul_result,
  output logic            o_mul_busy
);

  localparam int ITER = XLEN / 2 + 1;
  localparam int EW   = XLEN + 2;
  localparam int AW   = XLEN + 4;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t          state, state_nx;
  logic [EW-1:0]   mcand, mult;
  logic            q;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic            word_q;

  logic            rs1_sx, rs2_sx, accept, zero_op;
  logic [EW-1:0]   ext_rs1, ext_rs2;
  logic [2:0]      trip;
  logic [AW-1:0]   m_ext, pp, sum, acc_nx;
  logic [EW-1:0]   mult_nx;
  logic [2*XLEN-1:0] prod;
  logic [31:0]     lo32;
  logic [XLEN-1:0] sel;

  // Word mode forces the MUL encoding regardless of the op field.
  assign rs1_sx = i_mul_word || (i_mul_op != 2'b11);
  assign rs2_sx = i_mul_word || !i_mul_op[1];

  always_comb begin
    ext_rs1 = '0;
    ext_rs2 = '0;
    if (i_mul_word) begin
      ext_rs1 = {{(EW-32){i_mul_rs1[31]}}, i_mul_rs1[31:0]};
      ext_rs2 = {{(EW-32){i_mul_rs2[31]}}, i_mul_rs2[31:0]};
    end else begin
      ext_rs1 = {{2{rs1_sx & i_mul_rs1[XLEN-1]}}, i_mul_rs1};
      ext_rs2 = {{2{rs2_sx & i_mul_rs2[XLEN-1]}}, i_mul_rs2};
    end
  end

  assign accept = (state == S_IDLE) && i_mul_valid && !i_mul_flush;

`ifdef RISCV_BOOTH_ZERO_SKIP_EN
  assign zero_op = (ext_rs1 == '0) || (ext_rs2 == '0);
`else
  assign zero_op = 1'b0;
`endif

  // One Booth step; the last step's shifted value feeds the result register directly.
  always_comb begin
    trip  = {mult[1], mult[0], q};
    m_ext = {{2{mcand[EW-1]}}, mcand};
    pp    = '0;
    case (trip)
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
    sum     = acc + pp;
    acc_nx  = {{2{sum[AW-1]}}, sum[AW-1:2]};
    mult_nx = {sum[1:0], mult[EW-1:2]};
    prod    = {acc_nx[XLEN-3:0], mult_nx};
    lo32    = prod[31:0];
    if (word_q)              sel = XLEN'($signed(lo32));
    else if (op_q == 2'b00)  sel = prod[XLEN-1:0];
    else                     sel = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge i_mul_clk or posedge i_mul_rst) begin
    if (i_mul_rst) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = zero_op ? S_DONE : S_MUL;
      S_MUL: begin
        if (i_mul_flush)            state_nx = S_IDLE;
        else if (cnt == CW'(1))     state_nx = S_DONE;
      end
      S_DONE: if (i_mul_flush || i_mul_out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_mul_clk or posedge i_mul_rst) begin
    if (i_mul_rst) begin
      mcand        <= '0;
      mult         <= '0;
      q            <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      op_q         <= 2'b00;
      word_q       <= 1'b0;
      o_mul_result <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          mcand  <= ext_rs1;
          mult   <= ext_rs2;
          q      <= 1'b0;
          acc    <= '0;
          cnt    <= CW'(ITER);
          op_q   <= i_mul_word ? 2'b00 : i_mul_op;
          word_q <= i_mul_word;
          if (zero_op) o_mul_result <= '0;
        end
        S_MUL: if (!i_mul_flush) begin
          acc  <= acc_nx;
          mult <= mult_nx;
          q    <= mult[1];
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) o_mul_result <= sel;
        end
        default: ;
      endcase
    end
  end

  assign o_mul_ready = (state == S_IDLE);
  assign o_mul_valid = (state == S_DONE);
  assign o_mul_busy  = (state == S_MUL) || (state == S_DONE);

endmodule

// File: tb/tb_riscv_core_booth_r4.sv
// Directed + random bench for riscv_core_booth_r4 (XLEN=64) with an expected-result queue.
module tb_riscv_core_booth_r4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [1:0]  op = 2'b00;
  logic        word = 1'b0;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        res_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        busy;

  int compared = 0;
  int mismatched = 0;
  logic [63:0] sbq[$];

`ifdef RISCV_BOOTH_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif
  localparam int LAT = 34;

  always #5 clk = ~clk;

  riscv_core_booth_r4 #(.XLEN(64)) dut (
    .i_mul_clk(clk), .i_mul_rst(rst), .i_mul_valid(valid), .o_mul_ready(ready),
    .i_mul_op(op), .i_mul_word(word), .i_mul_rs1(rs1), .i_mul_rs2(rs2),
    .i_mul_flush(flush), .o_mul_valid(res_valid), .i_mul_out_ready(out_ready),
    .o_mul_result(result), .o_mul_busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] mop, input logic mw,
                                        input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] ea, eb, p;
    logic signed [63:0]  w;
    if (mw) begin
      w = 64'($signed(a[31:0])) * 64'($signed(b[31:0]));
      return 64'($signed(w[31:0]));
    end
    ea = (mop == 2'b11) ? {66'b0, a} : {{66{a[63]}}, a};
    eb = mop[1] ? {66'b0, b} : {{66{b[63]}}, b};
    p  = ea * eb;
    return (mop == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  // Drives one request for a single edge; returns #1 after the accepting edge.
  task automatic send(input string tag, input logic [1:0] o, input logic w,
                      input logic [63:0] a, input logic [63:0] b);
    check({tag, "_ready_idle"}, 64'(ready), 64'd1);
    op = o; word = w; rs1 = a; rs2 = b; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    check({tag, "_ready_after_accept"}, 64'(ready), 64'd0);
  endtask

  // Latency counts the accepting edge as edge 1.
  task automatic wait_result(input string tag, input int exp_lat, input int hold);
    int edges;
    logic [63:0] exp, held;
    edges = 1;
    while (!res_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    held = result;
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_hold_stable"}, result, held);
    end
    check({tag, "_sb_nonempty"}, 64'(sbq.size() > 0), 64'd1);
    exp = (sbq.size() > 0) ? sbq.pop_front() : 64'hx;
    check({tag, "_result"}, result, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_after_hs"}, 64'(res_valid), 64'd0);
    check({tag, "_ready_after_hs"}, 64'(ready), 64'd1);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int lat, input int hold);
    sbq.push_back(exp);
    send(tag, o, w, a, b);
    wait_result(tag, lat, hold);
  endtask

  initial begin
    int seen;
    logic [1:0]  ro;
    logic        rw;
    logic [63:0] ra, rb;

    #12;
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_result", result, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;

    run("mul_3x5", 2'b00, 1'b0, 64'd3, 64'd5, 64'h000000000000000F, LAT, 5);
    run("mulhu_max", 2'b11, 1'b0, '1, '1, 64'hFFFFFFFFFFFFFFFE, LAT, 0);
    run("mulh_min", 2'b01, 1'b0, 64'h8000000000000000, 64'h8000000000000000,
        64'h4000000000000000, LAT, 0);
    run("mulh_m1", 2'b01, 1'b0, '1, '1, 64'h0, LAT, 0);
    run("mulhsu_m1", 2'b10, 1'b0, '1, '1, 64'hFFFFFFFFFFFFFFFF, LAT, 0);
    run("mulw", 2'b00, 1'b1, 64'h000000007FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, LAT, 0);
    run("mulw_op11", 2'b11, 1'b1, 64'hABCD00007FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, LAT, 0);

    // Asynchronous reset in the middle of an operation; result was nonzero before.
    send("rst_mid", 2'b00, 1'b0, 64'd11, 64'd13);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(res_valid), 64'd0);
    check("rst_mid_ready", 64'(ready), 64'd1);
    check("rst_mid_result", result, 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    run("after_rst", 2'b00, 1'b0, 64'd100, 64'd200, 64'd20000, LAT, 0);

    // Flush during MUL: nothing delivered, unit idle right after.
    send("flush_mul", 2'b00, 1'b0, 64'd123, 64'd456);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_mul_ready", 64'(ready), 64'd1);
    check("flush_mul_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    check("flush_mul_no_valid", 64'(seen), 64'd0);
    run("mul_7x6", 2'b00, 1'b0, 64'd7, 64'd6, 64'h2A, LAT, 0);

    // Flush in IDLE blocks acceptance even with a valid request.
    valid = 1'b1; flush = 1'b1; op = 2'b00; word = 1'b0; rs1 = 64'd5; rs2 = 64'd5;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);
    check("flush_idle_ready", 64'(ready), 64'd1);

    // Flush in DONE beats out_ready and drops the result.
    send("flush_done", 2'b00, 1'b0, 64'd9, 64'd9);
    seen = 1;
    while (!res_valid && seen < 200) begin
      @(posedge clk); #1;
      seen++;
    end
    check("flush_done_reached", 64'(res_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_valid", 64'(res_valid), 64'd0);
    check("flush_done_ready", 64'(ready), 64'd1);

    run("zero_skip", 2'b00, 1'b0, 64'd0, 64'h1234, 64'd0, ZLAT, 2);
    run("zero_word", 2'b01, 1'b1, 64'hFFFFFFFF00000000, 64'd77, 64'd0, ZLAT, 0);

    for (int k = 0; k < 8; k++) begin
      ro = 2'($urandom_range(0, 3));
      rw = (k >= 6);
      ra = {$urandom, $urandom} | 64'h1;
      rb = {$urandom, $urandom} | 64'h1;
      run("rand", ro, rw, ra, rb, model(ro, rw, ra, rb), LAT, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
